// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline-control slice:
// forwarding-select codes and the data-memory wait FSM states.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN,
        WAIT
    } mem_state_t;

endpackage

// File: rtl/mips_fwd_unit.sv
// EX-stage operand forwarding select for one ALU operand.
// A result still in MEM is newer than one in WB, so MEM wins.
module mips_fwd_unit
    import mips_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            v_mem,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            v_wb,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_RF;
        if (v_mem && mem_reg_write && (mem_rd != '0) && (mem_rd == src))
            sel = FWD_MEM;
        else if (v_wb && wb_reg_write && (wb_rd != '0) && (wb_rd == src))
            sel = FWD_WB;
    end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: PC, stage valids, load-use
// stall, branch flush, forwarding and memory-latency freeze. Optional
// perf counters are enabled with `define PIPE_PERF_CNT_EN.
module mips_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               RA_W     = 5,
    parameter int               MEM_LAT  = 0,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_br_taken,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic            mem_access,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    output logic [XLEN-1:0] pc,
    output logic            hold_if_id,
    output logic            bubble_id_ex,
    output logic            freeze,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            v_id,
    output logic            v_ex,
    output logic            v_mem,
    output logic            v_wb
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_freeze
`endif
);

    localparam int              CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]   LAT_LOAD = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam bit              HAS_LAT  = (MEM_LAT > 0);

    mem_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic          mem_start;
    logic          load_use;
    logic          branch;
    logic          take_br;
    logic          take_stall;
    logic          unused_ex_reg_write;

    // A load always writes, so the load-use check keys on ex_mem_read alone.
    assign unused_ex_reg_write = ex_reg_write;

    assign load_use = v_ex && ex_mem_read && (ex_rd != '0) && v_id &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign branch   = v_ex && ex_br_taken;

    assign mem_start = HAS_LAT && (state == RUN) && v_mem && mem_access;
    assign freeze    = mem_start || ((state == WAIT) && (wait_cnt != '0));

    // Freeze masks branch and stall; they re-present once the pipe moves again.
    assign take_br    = !freeze && branch;
    assign take_stall = !freeze && !branch && load_use;

    assign hold_if_id   = take_stall;
    assign bubble_id_ex = take_br || take_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_start) begin
                        state    <= WAIT;
                        wait_cnt <= LAT_LOAD;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= RUN;
                    else                wait_cnt <= wait_cnt - CW'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else if (!freeze) begin
            if (branch)         pc <= ex_br_target;
            else if (!load_use) pc <= pc + XLEN'(4);
            v_wb  <= v_mem;
            v_mem <= v_ex;
            v_ex  <= v_id && !load_use && !branch;
            v_id  <= branch ? 1'b0 : (load_use ? v_id : 1'b1);
        end
    end

    mips_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .src(ex_rs), .v_mem(v_mem), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .v_wb(v_wb), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .sel(fwd_a)
    );

    mips_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .src(ex_rt), .v_mem(v_mem), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .v_wb(v_wb), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .sel(fwd_b)
    );

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_stall  <= '0;
            cnt_flush  <= '0;
            cnt_freeze <= '0;
        end else begin
            if (take_stall && (cnt_stall != '1))  cnt_stall  <= cnt_stall + CNT_W'(1);
            if (take_br && (cnt_flush != '1))     cnt_flush  <= cnt_flush + CNT_W'(1);
            if (freeze && (cnt_freeze != '1))     cnt_freeze <= cnt_freeze + CNT_W'(1);
        end
    end
`endif

endmodule
